// File: rtl/pattern_output_driver_pkg.sv
// Shared constants and channel state encoding for the pattern output path.
// Used by the output driver, cycle controller and memory wrapper.
package pattern_output_driver_pkg;

   localparam int MEM_ADDRESS_LENGTH = 7;
   localparam int DATA_WIDTH         = 16;
   localparam int DEAD_TIME_WIDTH    = 4;
   localparam int MEM_READ_LATENCY   = 1;

   typedef enum logic {
      CH_DRIVE = 1'b0,
      CH_DEAD  = 1'b1
   } ch_state_e;

endpackage

// File: rtl/pattern_output_driver_if.sv
// Sequence memory read bus between the output driver and the memory.
// master: mem_read_en/mem_row/mem_col out, mem_data in; slave: opposite.
interface pattern_output_driver_if
   import pattern_output_driver_pkg::*;
#(
   parameter int AW = MEM_ADDRESS_LENGTH,
   parameter int DW = DATA_WIDTH
);
   logic          mem_read_en;
   logic [AW-1:0] mem_row;
   logic [AW-1:0] mem_col;
   logic [DW-1:0] mem_data;

   modport master (
      output mem_read_en, mem_row, mem_col,
      input  mem_data
   );

   modport slave (
      input  mem_read_en, mem_row, mem_col,
      output mem_data
   );
endinterface

// File: rtl/pattern_output_driver_dead_time_channel.sv
// One output channel with break-before-make dead time.
// Ports: clock/reset, enable, target, off_level, dead_time -> drive, settled.
module dead_time_channel
   import pattern_output_driver_pkg::*;
#(
   parameter int DTW = DEAD_TIME_WIDTH
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           enable,
   input  logic           target,
   input  logic           off_level,
   input  logic [DTW-1:0] dead_time,
   output logic           drive,
   output logic           settled
);

   ch_state_e      state_q, state_d;
   logic [DTW-1:0] cnt_q, cnt_d;
   logic           committed_q, committed_d;
   logic           drive_q, drive_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      committed_d = committed_q;
      if (!enable) begin
         state_d     = CH_DRIVE;
         cnt_d       = '0;
         committed_d = off_level;
      end else begin
         unique case (state_q)
            CH_DRIVE: begin
               if (target != committed_q) begin
                  if (dead_time == '0) begin
                     committed_d = target;
                  end else begin
                     state_d = CH_DEAD;
                     cnt_d   = dead_time - 1'b1;
                  end
               end
            end
            CH_DEAD: begin
               // Whatever target is present at expiry wins.
               if (cnt_q == '0) begin
                  state_d     = CH_DRIVE;
                  committed_d = target;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = CH_DRIVE;
         endcase
      end
      // Pin follows the next state so drive is fully registered.
      drive_d = (state_d == CH_DEAD) ? off_level : committed_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= CH_DRIVE;
         cnt_q       <= '0;
         committed_q <= 1'b0;
         drive_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         committed_q <= committed_d;
         drive_q     <= drive_d;
      end
   end

   assign drive   = drive_q;
   assign settled = (state_q == CH_DRIVE) && (committed_q == target);

endmodule

// File: rtl/pattern_output_driver.sv
// Fetches the addressed pattern word, gates/inverts it and drives the pins
// through per-channel dead time. Ports: controller selects in, memory bus
// (mem), drive_out/drive_valid to the pins, cycle_done pulse to the host.
module pattern_output_driver
   import pattern_output_driver_pkg::*;
#(
   parameter int MAL = MEM_ADDRESS_LENGTH,
   parameter int DW  = DATA_WIDTH,
   parameter int DTW = DEAD_TIME_WIDTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [MAL-1:0]    row_select,
   input  logic [MAL-1:0]    col_select,
   input  logic              output_active,
   input  logic [DW-1:0]     inverter_select,
   input  logic              update_cycle_complete,
   input  logic              driver_enable,
   input  logic [DTW-1:0]    dead_time,
   pattern_output_driver_if.master mem,
   output logic [DW-1:0]     drive_out,
   output logic              drive_valid,
   output logic              cycle_done
);

   logic [MAL-1:0] mem_row_q, mem_row_d;
   logic [MAL-1:0] mem_col_q, mem_col_d;
   logic           mem_read_en_q, mem_read_en_d;
   logic           act_a_q, act_a_d;
   logic [DW-1:0]  data_b_q, data_b_d;
   logic           act_b_q, act_b_d;
   logic           ucc_q, ucc_d;
   logic           cycle_done_q, cycle_done_d;
   logic           drive_valid_q, drive_valid_d;
   logic [DW-1:0]  target;
   logic [DW-1:0]  settled;

   assign target = (act_b_q ? data_b_q : '0) ^ inverter_select;

   always_comb begin
      mem_row_d     = row_select;
      mem_col_d     = col_select;
      mem_read_en_d = driver_enable;
      act_a_d       = output_active;
      data_b_d      = mem.mem_data;
      act_b_d       = act_a_q;
      ucc_d         = update_cycle_complete;
      cycle_done_d  = update_cycle_complete & ~ucc_q;
      drive_valid_d = driver_enable & (&settled);
   end

   // ucc_q resets high so a flag already high at release is not an edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_row_q     <= '0;
         mem_col_q     <= '0;
         mem_read_en_q <= 1'b0;
         act_a_q       <= 1'b0;
         data_b_q      <= '0;
         act_b_q       <= 1'b0;
         ucc_q         <= 1'b1;
         cycle_done_q  <= 1'b0;
         drive_valid_q <= 1'b0;
      end else begin
         mem_row_q     <= mem_row_d;
         mem_col_q     <= mem_col_d;
         mem_read_en_q <= mem_read_en_d;
         act_a_q       <= act_a_d;
         data_b_q      <= data_b_d;
         act_b_q       <= act_b_d;
         ucc_q         <= ucc_d;
         cycle_done_q  <= cycle_done_d;
         drive_valid_q <= drive_valid_d;
      end
   end

   for (genvar i = 0; i < DW; i++) begin : g_ch
      dead_time_channel #(.DTW(DTW)) u_ch (
         .clock     (clock),
         .reset     (reset),
         .enable    (driver_enable),
         .target    (target[i]),
         .off_level (inverter_select[i]),
         .dead_time (dead_time),
         .drive     (drive_out[i]),
         .settled   (settled[i])
      );
   end

   assign mem.mem_row     = mem_row_q;
   assign mem.mem_col     = mem_col_q;
   assign mem.mem_read_en = mem_read_en_q;
   assign drive_valid     = drive_valid_q;
   assign cycle_done      = cycle_done_q;

endmodule

// File: tb/tb_pattern_output_driver.sv
// Scoreboard bench for pattern_output_driver.
// Expectations are queued with a due cycle and checked on the falling edge.
module tb_pattern_output_driver;
   import pattern_output_driver_pkg::*;

   localparam int S_DRV = 0;
   localparam int S_VAL = 1;
   localparam int S_ROW = 2;
   localparam int S_COL = 3;
   localparam int S_REN = 4;
   localparam int S_DON = 5;

   typedef struct {
      int          due;
      int          sel;
      logic [31:0] exp;
      string       tag;
   } sb_t;

   logic                          clock;
   logic                          reset;
   logic [MEM_ADDRESS_LENGTH-1:0] row_select;
   logic [MEM_ADDRESS_LENGTH-1:0] col_select;
   logic                          output_active;
   logic [DATA_WIDTH-1:0]         inverter_select;
   logic                          update_cycle_complete;
   logic                          driver_enable;
   logic [DEAD_TIME_WIDTH-1:0]    dead_time;
   logic [DATA_WIDTH-1:0]         drive_out;
   logic                          drive_valid;
   logic                          cycle_done;

   sb_t sb[$];
   int  cyc = 0;
   int  last_due = 0;
   int  n_vec = 0;
   int  n_err = 0;

   pattern_output_driver_if mif ();

   pattern_output_driver dut (
      .clock                 (clock),
      .reset                 (reset),
      .row_select            (row_select),
      .col_select            (col_select),
      .output_active         (output_active),
      .inverter_select       (inverter_select),
      .update_cycle_complete (update_cycle_complete),
      .driver_enable         (driver_enable),
      .dead_time             (dead_time),
      .mem                   (mif.master),
      .drive_out             (drive_out),
      .drive_valid           (drive_valid),
      .cycle_done            (cycle_done)
   );

   function automatic logic [15:0] memw(input logic [6:0] r,
                                        input logic [6:0] c);
      if (r == 7'd2 && c == 7'd5) return 16'hA5A5;
      return {2'b00, r, c};
   endfunction

   assign mif.mem_data = memw(mif.mem_row, mif.mem_col);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_DRV:   return 32'(drive_out);
         S_VAL:   return 32'(drive_valid);
         S_ROW:   return 32'(mif.mem_row);
         S_COL:   return 32'(mif.mem_col);
         S_REN:   return 32'(mif.mem_read_en);
         default: return 32'(cycle_done);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      foreach (sb[i]) begin
         if (sb[i].due == cyc) chk(sb[i].tag, observe(sb[i].sel), sb[i].exp);
      end
   end

   task automatic exa(input int due, input int sel, input logic [31:0] v,
                      input string tag);
      sb.push_back('{due, sel, v, tag});
      if (due > last_due) last_due = due;
   endtask

   task automatic ex(input int off, input int sel, input logic [31:0] v,
                     input string tag);
      exa(cyc + off, sel, v, tag);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int e;
      reset                 = 1'b1;
      row_select            = '0;
      col_select            = '0;
      output_active         = 1'b0;
      inverter_select       = '0;
      update_cycle_complete = 1'b0;
      driver_enable         = 1'b0;
      dead_time             = '0;

      step(1);
      ex(0, S_DRV, 32'h0, "rst_drive");
      ex(0, S_VAL, 32'h0, "rst_valid");
      ex(0, S_ROW, 32'h0, "rst_row");
      ex(0, S_COL, 32'h0, "rst_col");
      ex(0, S_REN, 32'h0, "rst_ren");
      ex(0, S_DON, 32'h0, "rst_done");
      step(1);
      reset = 1'b0;
      step(1);

      // latency
      driver_enable = 1'b1;
      output_active = 1'b1;
      row_select    = 7'd2;
      col_select    = 7'd5;
      ex(1, S_ROW, 32'd2, "lat_row");
      ex(1, S_COL, 32'd5, "lat_col");
      ex(1, S_REN, 32'd1, "lat_ren");
      ex(2, S_DRV, 32'h0, "lat_drive_early");
      ex(3, S_DRV, 32'hA5A5, "lat_drive");
      ex(3, S_VAL, 32'd0, "lat_valid_low");
      ex(4, S_VAL, 32'd1, "lat_valid");
      ex(4, S_DON, 32'd0, "idle_done");
      step(6);

      // inversion and gating
      inverter_select = 16'h00FF;
      ex(3, S_DRV, 32'hA55A, "inv_active");
      step(4);
      output_active = 1'b0;
      ex(2, S_DRV, 32'hA55A, "gate_hold");
      ex(3, S_DRV, 32'h00FF, "gate_off");
      ex(4, S_VAL, 32'd1, "gate_valid");
      step(6);

      // dead time on channel 0
      inverter_select = '0;
      output_active   = 1'b1;
      row_select      = 7'd0;
      col_select      = 7'd0;
      ex(4, S_DRV, 32'h0, "dt_base");
      step(6);
      dead_time  = 4'd3;
      col_select = 7'd1;
      ex(3, S_DRV, 32'h0000, "dt_dead0");
      ex(5, S_DRV, 32'h0000, "dt_dead2");
      ex(6, S_DRV, 32'h0001, "dt_on");
      ex(4, S_VAL, 32'd0, "dt_valid_a");
      ex(6, S_VAL, 32'd0, "dt_valid_b");
      ex(7, S_VAL, 32'd1, "dt_valid_c");
      step(8);

      // target returns during dead period
      c          = cyc;
      dead_time  = 4'd4;
      col_select = 7'd3;
      step(2);
      col_select = 7'd1;
      exa(c + 3, S_DRV, 32'h0001, "dtc_dead");
      exa(c + 6, S_DRV, 32'h0001, "dtc_last");
      exa(c + 7, S_DRV, 32'h0001, "dtc_expire");
      exa(c + 7, S_VAL, 32'd0, "dtc_valid_low");
      exa(c + 8, S_VAL, 32'd1, "dtc_valid");
      step(8);

      // enable drop mid-dead
      c          = cyc;
      dead_time  = 4'd3;
      col_select = 7'd2;
      step(4);
      driver_enable   = 1'b0;
      inverter_select = 16'h0F0D;
      exa(c + 4, S_DRV, 32'h0000, "dis_dead");
      exa(c + 5, S_DRV, 32'h0F0D, "dis_off");
      exa(c + 5, S_REN, 32'd0, "dis_ren");
      exa(c + 5, S_VAL, 32'd0, "dis_valid");
      step(2);

      // re-enable from off level
      e               = cyc;
      driver_enable   = 1'b1;
      inverter_select = '0;
      dead_time       = 4'd2;
      exa(e + 1, S_DRV, 32'h0000, "ren_dead0");
      exa(e + 1, S_REN, 32'd1, "ren_ren");
      exa(e + 2, S_DRV, 32'h0000, "ren_dead1");
      exa(e + 3, S_DRV, 32'h0002, "ren_on");
      exa(e + 3, S_VAL, 32'd0, "ren_valid_low");
      exa(e + 4, S_VAL, 32'd1, "ren_valid");
      step(6);

      // async reset between edges
      #2;
      reset = 1'b1;
      ex(0, S_DRV, 32'h0, "arst_drive");
      ex(0, S_COL, 32'h0, "arst_col");
      ex(0, S_VAL, 32'h0, "arst_valid");
      ex(0, S_REN, 32'h0, "arst_ren");
      step(2);
      reset = 1'b0;
      step(2);

      // cycle_done edge detect
      update_cycle_complete = 1'b1;
      ex(1, S_DON, 32'd1, "done_pulse");
      ex(2, S_DON, 32'd0, "done_end");
      ex(5, S_DON, 32'd0, "done_hold5");
      ex(10, S_DON, 32'd0, "done_hold10");
      step(10);
      update_cycle_complete = 1'b0;
      step(2);
      update_cycle_complete = 1'b1;
      step(2);
      #2;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) ex(k, S_DON, 32'd0, "done_after_rst");
      step(6);
      update_cycle_complete = 1'b0;
      step(2);
      update_cycle_complete = 1'b1;
      ex(1, S_DON, 32'd1, "done_rearm");
      ex(2, S_DON, 32'd0, "done_rearm_end");
      step(4);

      while (cyc <= last_due + 1) step(1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pattern_output_driver.md
Name: pattern_output_driver

Overview:
Sits directly downstream of the cycle controller. Each clock it takes the controller's row/column select, output-active window, inverter mask and update-complete flag, and fetches the addressed pattern word from the sequence memory. It then applies the active gating and the polarity inversion, and inserts per-channel break-before-make dead time before driving the motor pins. It also produces a single-cycle end-of-update pulse for the host/sequencer.

Parameters:
MEM_ADDRESS_LENGTH, 7, width of row and column addresses
DATA_WIDTH, 16, pattern word width = number of output channels
DEAD_TIME_WIDTH, 4, width of dead-time count

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
row_select  input  MEM_ADDRESS_LENGTH  row address from cycle controller
col_select  input  MEM_ADDRESS_LENGTH  column address from cycle controller
output_active  input  1  pulse-on window from cycle controller
inverter_select  input  DATA_WIDTH  per-channel polarity mask; bit i = channel i off level
update_cycle_complete  input  1  level flag from cycle controller
driver_enable  input  1  master output enable
dead_time  input  DEAD_TIME_WIDTH  dead-time cycles; 0 = disabled
mem_read_en  output  1  memory read strobe
mem_row  output  MEM_ADDRESS_LENGTH  registered memory row address
mem_col  output  MEM_ADDRESS_LENGTH  registered memory column address
mem_data  input  DATA_WIDTH  memory read data, valid one cycle after mem_row/mem_col update
drive_out  output  DATA_WIDTH  motor pin drive
drive_valid  output  1  all channels settled on the pattern target
cycle_done  output  1  one-cycle pulse per update completion

Behaviour:
- Reset asserted (async): mem_row=0, mem_col=0, mem_read_en=0, drive_out=0, drive_valid=0, cycle_done=0. Pipeline regs cleared, every channel in DRIVE with committed=0 and counter=0.
- Stage A (edge t+1): mem_row<=row_select, mem_col<=col_select, mem_read_en<=driver_enable, act_a<=output_active.
- Stage B (edge t+2): data_b<=mem_data, act_b<=act_a. target = (act_b ? data_b : 0) XOR inverter_select.
- Input-to-drive_out latency with dead_time=0: 3 edges, fixed.
- Per-channel FSM (i = 0..DATA_WIDTH-1), states DRIVE and DEAD:
  - DRIVE: drive_out[i]=committed[i].
  - In DRIVE with target[i]!=committed[i]:
    - dead_time=0: committed[i]<=target[i] next edge.
    - dead_time>0: go to DEAD, cnt<=dead_time-1.
  - DEAD: drive_out[i]=inverter_select[i] (off level). cnt decrements each edge.
  - DEAD with cnt=0: committed[i]<=current target[i], return to DRIVE.
  - Target changes during DEAD do not restart the count; the target sampled at expiry wins, even if it equals the old committed value.
  - dead_time changes take effect only at the next DRIVE->DEAD entry.
- drive_out is registered; channels are independent.
- driver_enable low:
  - mem_read_en<=0.
  - All channels forced to DRIVE with committed<=inverter_select (off level) next edge; counters cleared.
  - drive_valid=0.
- On re-enable, a channel sitting at its off level whose target differs goes through a full dead period.
- drive_valid (registered) = driver_enable AND every channel in DRIVE AND committed==target.
- cycle_done: one-cycle registered pulse on the rising edge of update_cycle_complete (edge detect, 1 edge latency). A level held high gives exactly one pulse. If reset is asserted while the flag is high, no pulse is issued after reset releases until the flag falls and rises again; the edge-detect reg resets to 1.
- Reset mid-dead-time: the channel returns to DRIVE, committed=0; no residual count.

Decomposition:
- Shared package: DATA_WIDTH/address-width constants, per-channel state encoding (DRIVE=1'b0, DEAD=1'b1), and the memory read latency constant (1), shared with the cycle controller and memory wrapper.
- Natural sub-module: dead_time_channel, one per channel via generate. Contains the state, counter and committed bit; inputs target, off_level, dead_time, enable; outputs drive and settled.
- The top level holds the address/data pipeline, target formation, cycle_done edge detect and the drive_valid reduction.

Test Plan:
- Reset/latency: reset then release; driver_enable=1, dead_time=0, inverter_select=0, output_active=1, row=2/col=5 with mem model returning 16'hA5A5 -> mem_row=2/mem_col=5 after 1 edge; drive_out=16'hA5A5 after 3 edges; drive_valid=1 one edge later.
- Inversion/gating: inverter_select=16'h00FF, data 16'hA5A5, output_active toggled 1->0 -> drive_out 16'hA55A while active, 16'h00FF three edges after active falls.
- Dead time: dead_time=3, channel 0 target 0->1 (inverter 0) -> drive_out[0]=0 for 3 edges, then 1; drive_valid low throughout dead period; other unchanged channels hold.
- Target change during DEAD: dead_time=4, target[1] goes 0->1 then back to 0 after 2 cycles -> channel 1 stays off for 4 edges, then drives 0; counter not restarted.
- Enable drop mid-dead and async reset: deassert driver_enable during a dead period -> drive_out=inverter_select next edge, mem_read_en=0. Assert reset between clock edges -> drive_out=0 immediately.
- cycle_done: hold update_cycle_complete high for 10 cycles -> exactly one 1-cycle pulse 1 edge after rise. Reset while high, release -> no pulse until a 0->1 transition.
